link_sender: RTL and testbench
==============================

# link_sender

Output stage of the NIC link path, directly downstream of `link_allocator`. Each cycle it raises one allocation request per output virtual-channel FIFO that is non-empty and holds a downstream credit, and accepts the granted channel id back from the allocator. It then pops the granted FIFO and drives the flit onto the link, registered, with valid and VC id. It keeps one credit counter per channel, replenished by credit-return pulses from the downstream router.

## Interface
Parameters:
- `N_REQUEST_SIGNAL`, 6, number of virtual channels / FIFOs; equals the allocator's request width.
- `N_BITS_POINTER`, `clog2(N_REQUEST_SIGNAL)`, width of the channel id.
- `FLIT_WIDTH`, 64, flit width in bits.
- `N_CREDITS`, 4, downstream buffer depth per channel; initial and maximum credit count.
- `CREDIT_WIDTH`, `clog2(N_CREDITS+1)`, width of each credit counter.

Ports:
- `clk`, input, 1, single clock; all state updates on its rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `flit_i`, input, `N_REQUEST_SIGNAL*FLIT_WIDTH`, head flit of each FIFO; channel k occupies bits `[k*FLIT_WIDTH +: FLIT_WIDTH]`.
- `empty_i`, input, `N_REQUEST_SIGNAL`, FIFO empty flags.
- `pop_o`, output, `N_REQUEST_SIGNAL`, combinational pop strobe to the FIFOs; zero or one-hot.
- `r_la_o`, output, `N_REQUEST_SIGNAL`, combinational requests to the allocator.
- `g_channel_id_i`, input, `N_BITS_POINTER`, granted channel id from the allocator; combinational, same cycle as the requests.
- `credit_i`, input, `N_REQUEST_SIGNAL`, credit-return pulses; at most one per channel per cycle, several channels may pulse together.
- `flit_o`, output, `FLIT_WIDTH`, registered link flit.
- `valid_o`, output, 1, registered link valid.
- `vc_id_o`, output, `N_BITS_POINTER`, registered VC id of `flit_o`.
- `credit_err_o`, output, 1, sticky flag: a credit was returned to a channel already at `N_CREDITS`.

## Operation
- Request logic:
  - `credit[k]` is a registered counter.
  - `r_la_o[k] = !empty_i[k] && (credit[k] != 0)`.
  - The request uses the registered count only, so a credit arriving this cycle does not enable a request this cycle.
- Grant qualification: a grant is valid iff `g_channel_id_i < N_REQUEST_SIGNAL` and `r_la_o[g_channel_id_i]` is 1.
  - An out-of-range id, or an id whose request is low, is ignored: no pop, no send.
  - The allocator drives an id even when idle; this qualification is the only filter.
- On a valid grant to channel g:
  - `pop_o[g] = 1` in the same cycle.
  - At the clock edge: `flit_o <= flit_i[g]`, `vc_id_o <= g`, `valid_o <= 1`.
  - `credit[g]` decrements.
- No valid grant: `valid_o <= 0`; `flit_o` and `vc_id_o` hold their previous values.
- Credit update per channel, evaluated each edge:
  - send only: count − 1.
  - `credit_i` only: count + 1.
  - Both in the same cycle: count unchanged.
  - Neither: unchanged.
- Saturation:
  - Credit return with count = `N_CREDITS` and no send that cycle: count stays at `N_CREDITS` and `credit_err_o <= 1`.
  - `credit_err_o` clears only on `rst`.
- Underflow is impossible: a send requires count ≠ 0.
- At most one flit per cycle; link throughput is 1 flit/cycle when grants are continuous.

## Timing
- Reset values, with `rst` sampled high on an edge:
  - every `credit[k] = N_CREDITS`.
  - `valid_o = 0`, `flit_o = 0`, `vc_id_o = 0`, `credit_err_o = 0`.
- During reset, `r_la_o` and `pop_o` are forced to 0 combinationally.
- Reset mid-operation: an in-flight registered flit is dropped (`valid_o` is 0 the following cycle), and all counts return to `N_CREDITS` regardless of outstanding flits.
- Latency:
  - Grant cycle T → `pop_o` at T → `flit_o` / `valid_o` at T+1.
  - Credit pulse at T → counter updated at T+1 edge → request may re-assert in cycle T+1.
- Back-to-back grants to the same channel are allowed while its count > 0 and its FIFO is non-empty. With `N_CREDITS` = 4 and no returns, the 5th consecutive request is suppressed.

## Test plan
- Reset then idle: `empty_i` = all 1s for 10 cycles → `r_la_o` = 0, `pop_o` = 0, `valid_o` = 0, all counts = 4, `credit_err_o` = 0.
- Single send: `empty_i` = 6'b111110, `flit_i[0]` = 64'hA5, `g_channel_id_i` = 0 →
  - `r_la_o` = 6'b000001 and `pop_o[0]` = 1 in that cycle.
  - Next cycle: `valid_o` = 1, `flit_o` = 64'hA5, `vc_id_o` = 0; `credit[0]` = 3.
- Credit exhaustion: channel 2 non-empty, granted 4 consecutive cycles, no `credit_i` →
  - 4 valid flits with `vc_id_o` = 2.
  - 5th cycle: `r_la_o[2]` = 0, no pop, `valid_o` = 0.
  - Pulse `credit_i[2]` once → `r_la_o[2]` = 1 the next cycle.
- Invalid grant: `r_la_o` = 6'b000100, `g_channel_id_i` = 1, then `g_channel_id_i` = 7 → no pop, `valid_o` = 0, counts unchanged.
- Simultaneous send and return: channel 3 at count 2, granted while `credit_i[3]` = 1 → count stays 2, flit sent.
  - Then `credit_i[5]` pulsed with `credit[5]` = 4 → `credit[5]` stays 4, `credit_err_o` = 1 until `rst`.
- Mid-operation reset: `rst` asserted the cycle after a grant → `valid_o` = 0 the next cycle, all counts = 4, `credit_err_o` = 0.

Source files
------------

// File: rtl/link_sender.sv
// link_sender: output stage of the NIC link path. Raises one allocation request
// per virtual channel that has a non-empty FIFO and a downstream credit. It
// qualifies the allocator's grant, pops the granted FIFO and registers the flit
// onto the link. It also keeps one credit counter per channel.
module link_sender #(
  parameter int N_REQUEST_SIGNAL = 6,
  parameter int N_BITS_POINTER   = $clog2(N_REQUEST_SIGNAL),
  parameter int FLIT_WIDTH       = 64,
  parameter int N_CREDITS        = 4,
  parameter int CREDIT_WIDTH     = $clog2(N_CREDITS + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQUEST_SIGNAL*FLIT_WIDTH-1:0] flit_i,
  input  logic [N_REQUEST_SIGNAL-1:0]            empty_i,
  output logic [N_REQUEST_SIGNAL-1:0]            pop_o,
  output logic [N_REQUEST_SIGNAL-1:0]            r_la_o,
  input  logic [N_BITS_POINTER-1:0]              g_channel_id_i,
  input  logic [N_REQUEST_SIGNAL-1:0]            credit_i,
  output logic [FLIT_WIDTH-1:0]                  flit_o,
  output logic                                   valid_o,
  output logic [N_BITS_POINTER-1:0]              vc_id_o,
  output logic                                   credit_err_o
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(N_CREDITS);

  // Per-channel downstream credit counters (registered).
  logic [CREDIT_WIDTH-1:0]     credit_q [N_REQUEST_SIGNAL];
  logic [CREDIT_WIDTH-1:0]     credit_d [N_REQUEST_SIGNAL];

  // Stage p0: combinational grant qualification and flit selection.
  logic                        send_p0;
  logic [FLIT_WIDTH-1:0]       flit_p0;
  logic [N_BITS_POINTER-1:0]   vc_p0;
  logic                        ovf_p0;

  // Stage p1: registered link outputs.
  logic                        vld_p1;
  logic [FLIT_WIDTH-1:0]       flit_p1;
  logic [N_BITS_POINTER-1:0]   vc_p1;
  logic                        err_p1;

  // Next credit count for one channel. A send and a return in the same cycle
  // cancel out; a lone return at the ceiling saturates instead of wrapping.
  function automatic logic [CREDIT_WIDTH-1:0] credit_next(
    input logic [CREDIT_WIDTH-1:0] cnt,
    input logic                    send,
    input logic                    ret
  );
    logic [CREDIT_WIDTH-1:0] res;
    res = cnt;
    if (send && !ret) begin
      res = cnt - CREDIT_WIDTH'(1);
    end else if (ret && !send) begin
      res = (cnt == CREDIT_MAX) ? CREDIT_MAX : cnt + CREDIT_WIDTH'(1);
    end
    return res;
  endfunction

  // Flags a credit returned to a channel that already holds its full allowance.
  function automatic logic credit_overflow(
    input logic [CREDIT_WIDTH-1:0] cnt,
    input logic                    send,
    input logic                    ret
  );
    return ret && !send && (cnt == CREDIT_MAX);
  endfunction

  // Requests use only the registered count; reset forces them low.
  always_comb begin
    r_la_o = '0;
    for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
      r_la_o[k] = !rst && !empty_i[k] && (credit_q[k] != '0);
    end
  end

  // A grant counts only when it names an in-range channel that is requesting;
  // the allocator drives an id even when idle, so this is the only filter.
  always_comb begin
    pop_o   = '0;
    send_p0 = 1'b0;
    flit_p0 = '0;
    vc_p0   = '0;
    for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
      if ((g_channel_id_i == N_BITS_POINTER'(k)) && r_la_o[k]) begin
        pop_o[k] = 1'b1;
        send_p0  = 1'b1;
        flit_p0  = flit_i[k*FLIT_WIDTH +: FLIT_WIDTH];
        vc_p0    = N_BITS_POINTER'(k);
      end
    end
  end

  // Per-channel credit update and saturation detection.
  always_comb begin
    ovf_p0 = 1'b0;
    for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
      credit_d[k] = credit_next(credit_q[k], pop_o[k], credit_i[k]);
      if (credit_overflow(credit_q[k], pop_o[k], credit_i[k])) begin
        ovf_p0 = 1'b1;
      end
    end
  end

  // Credit counters return to full on reset, dropping any outstanding flits.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
      if (rst) begin
        credit_q[k] <= CREDIT_MAX;
      end else begin
        credit_q[k] <= credit_d[k];
      end
    end
  end

  // Link register: flit and VC id hold when nothing is sent; error flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
      vc_p1   <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= send_p0;
      if (send_p0) begin
        flit_p1 <= flit_p0;
        vc_p1   <= vc_p0;
      end
      if (ovf_p0) begin
        err_p1 <= 1'b1;
      end
    end
  end

  assign valid_o      = vld_p1;
  assign flit_o       = flit_p1;
  assign vc_id_o      = vc_p1;
  assign credit_err_o = err_p1;

endmodule

// File: tb/tb_link_sender.sv
// tb_link_sender: directed and random stimulus for link_sender, checked every
// cycle against a transaction-level model of credits and the link register.
module tb_link_sender;

  localparam int N  = 6;
  localparam int PW = 3;
  localparam int FW = 64;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*FW-1:0] flit_bus = '0;
  logic [N-1:0]    empty_i = '1;
  logic [N-1:0]    pop_o;
  logic [N-1:0]    r_la_o;
  logic [PW-1:0]   g_channel_id_i = '0;
  logic [N-1:0]    credit_i = '0;
  logic [FW-1:0]   flit_o;
  logic            valid_o;
  logic [PW-1:0]   vc_id_o;
  logic            credit_err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state, starting from the reset condition.
  int          cnt_m [N];
  logic        err_m  = 1'b0;
  logic        vld_m  = 1'b0;
  logic [FW-1:0] flit_m = '0;
  logic [PW-1:0] vc_m   = '0;

  link_sender #(
    .N_REQUEST_SIGNAL(N),
    .N_BITS_POINTER  (PW),
    .FLIT_WIDTH      (FW),
    .N_CREDITS       (NC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_i        (flit_bus),
    .empty_i       (empty_i),
    .pop_o         (pop_o),
    .r_la_o        (r_la_o),
    .g_channel_id_i(g_channel_id_i),
    .credit_i      (credit_i),
    .flit_o        (flit_o),
    .valid_o       (valid_o),
    .vc_id_o       (vc_id_o),
    .credit_err_o  (credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_req(input logic r, input logic [N-1:0] e);
    logic [N-1:0] q;
    q = '0;
    for (int k = 0; k < N; k++) q[k] = !r && !e[k] && (cnt_m[k] > 0);
    return q;
  endfunction

  // One clock cycle: apply inputs, check at the falling edge, advance the model.
  task automatic cycle(input logic r, input logic [N-1:0] e, input logic [PW-1:0] g,
                       input logic [N-1:0] c);
    logic [N-1:0] req_m;
    logic [N-1:0] pop_m;
    logic         gv;
    int           gi;
    rst = r; empty_i = e; g_channel_id_i = g; credit_i = c;
    @(negedge clk);
    req_m = model_req(r, e);
    gi = int'(g);
    gv = 1'b0;
    if (gi < N) gv = req_m[gi];
    pop_m = gv ? N'(1 << gi) : '0;
    check("r_la", 64'(r_la_o), 64'(req_m));
    check("pop", 64'(pop_o), 64'(pop_m));
    check("valid", 64'(valid_o), 64'(vld_m));
    check("flit", flit_o, flit_m);
    check("vc_id", 64'(vc_id_o), 64'(vc_m));
    check("credit_err", 64'(credit_err_o), 64'(err_m));
    for (int k = 0; k < N; k++)
      check($sformatf("credit%0d", k), 64'(dut.credit_q[k]), 64'(cnt_m[k]));
    if (r) begin
      for (int k = 0; k < N; k++) cnt_m[k] = NC;
      err_m = 1'b0; vld_m = 1'b0; flit_m = '0; vc_m = '0;
    end else begin
      vld_m = gv;
      if (gv) begin
        flit_m = flit_bus[gi*FW +: FW];
        vc_m   = g;
      end
      for (int k = 0; k < N; k++) begin
        if (pop_m[k] && !c[k]) cnt_m[k]--;
        else if (c[k] && !pop_m[k]) begin
          if (cnt_m[k] == NC) err_m = 1'b1;
          else cnt_m[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0]  e;
    logic [N-1:0]  c;
    logic [PW-1:0] g;
    logic [N-1:0]  req;
    logic          r;
    for (int k = 0; k < N; k++) cnt_m[k] = NC;

    // Reset, then idle with every FIFO empty.
    cycle(1'b1, '1, 3'd0, '0);
    cycle(1'b1, '1, 3'd0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '1, 3'd0, '0);

    // Single send on channel 0.
    flit_bus[0 +: FW] = 64'hA5;
    cycle(1'b0, 6'b111110, 3'd0, '0);
    cycle(1'b0, '1, 3'd0, '0);

    // Credit exhaustion on channel 2, then one credit return.
    for (int i = 0; i < 5; i++) begin
      flit_bus[2*FW +: FW] = 64'hC200 + 64'(i);
      cycle(1'b0, 6'b111011, 3'd2, '0);
    end
    cycle(1'b0, 6'b111011, 3'd7, 6'b000100);
    cycle(1'b0, 6'b111011, 3'd2, '0);
    cycle(1'b0, '1, 3'd0, 6'b000100);
    cycle(1'b0, '1, 3'd0, 6'b000100);

    // Invalid grants: wrong channel, then out of range.
    cycle(1'b0, 6'b111011, 3'd1, '0);
    cycle(1'b0, 6'b111011, 3'd7, '0);
    cycle(1'b0, 6'b111011, 3'd6, '0);

    // Channel 3 down to two credits, then a send with a simultaneous return.
    flit_bus[3*FW +: FW] = 64'h3333_0000_DEAD_BEEF;
    cycle(1'b0, 6'b110111, 3'd3, '0);
    cycle(1'b0, 6'b110111, 3'd3, '0);
    cycle(1'b0, 6'b110111, 3'd3, 6'b001000);
    // Return to a full channel 5 sets the sticky error.
    cycle(1'b0, '1, 3'd0, 6'b100000);
    for (int i = 0; i < 3; i++) cycle(1'b0, '1, 3'd0, '0);

    // Reset the cycle after a grant.
    cycle(1'b0, 6'b111110, 3'd0, '0);
    cycle(1'b1, 6'b111110, 3'd0, '0);
    cycle(1'b0, '1, 3'd0, '0);
    cycle(1'b0, '1, 3'd0, '0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      for (int w = 0; w < (N*FW)/32; w++) flit_bus[w*32 +: 32] = $urandom;
      r = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N; k++) e[k] = ($urandom_range(0, 9) < 3);
      for (int k = 0; k < N; k++)
        c[k] = ($urandom_range(0, 5) == 0) && (cnt_m[k] < NC || $urandom_range(0, 29) == 0);
      req = model_req(r, e);
      g = PW'($urandom_range(0, 7));
      if (req != '0 && $urandom_range(0, 9) < 7) begin
        for (int t = 0; t < 32; t++) begin
          g = PW'($urandom_range(0, N - 1));
          if (req[g]) break;
        end
      end
      cycle(r, e, g, c);
    end
    cycle(1'b0, '1, 3'd0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
